// File: rtl/cam_pixel_capture_pkg.sv
// Shared definitions for the camera pixel capture block: FSM encoding,
// bytes-per-pixel limits and the drop counter width.
package cam_pixel_capture_pkg;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [ST_W-1:0] ST_LINE     = 2'd2;

    localparam int BPP_MIN = 1;
    localparam int BPP_MAX = 4;
    localparam int BIDX_W  = $clog2(BPP_MAX);

    localparam int DROP_W = 16;

    // Saturating increment for the dropped-pixel counter.
    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + DROP_W'(1);
        end
    endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// Two-flop synchroniser for one camera timing line, with rise/fall detect
// taken between the first and second stage.
module cam_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    // Synchroniser stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign level_o = s1_q;
    assign rise_o  = s1_q & ~s2_q;
    assign fall_o  = ~s1_q & s2_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Captures pixels from a parallel CMOS sensor into the clk domain, applying a
// per-frame crop window and power-of-two decimation before the output FIFO.
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int BPP  = 2,
    parameter int X_W  = 11,
    parameter int Y_W  = 10,
    parameter int FC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic               clr_status_i,
    input  logic               cmos_pclk_i,
    input  logic               cmos_href_i,
    input  logic               cmos_vsync_i,
    input  logic [7:0]         cmos_db_i,
    input  logic [X_W-1:0]     win_x0_i,
    input  logic [X_W-1:0]     win_x1_i,
    input  logic [Y_W-1:0]     win_y0_i,
    input  logic [Y_W-1:0]     win_y1_i,
    input  logic [1:0]         decim_i,
    input  logic               out_full_i,
    output logic               out_valid_o,
    output logic [8*BPP-1:0]   out_data_o,
    output logic               out_sof_o,
    output logic               out_eol_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic [FC_W-1:0]    frame_cnt_o,
    output logic               overflow_o,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    localparam int PW = 8 * BPP;
    localparam logic [X_W-1:0]    X_ONES    = {X_W{1'b1}};
    localparam logic [Y_W-1:0]    Y_ONES    = {Y_W{1'b1}};
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPP - BPP_MIN);

    logic pclk_rise_s, pclk_level_unused_s, pclk_fall_unused_s;
    logic href_level_s, href_rise_s, href_fall_s;
    logic vsync_rise_s, vsync_fall_s, vsync_level_unused_s;

    cam_edge_sync u_sync_pclk (
        .clk(clk), .rst_n(rst_n), .d_i(cmos_pclk_i),
        .level_o(pclk_level_unused_s), .rise_o(pclk_rise_s), .fall_o(pclk_fall_unused_s)
    );
    cam_edge_sync u_sync_href (
        .clk(clk), .rst_n(rst_n), .d_i(cmos_href_i),
        .level_o(href_level_s), .rise_o(href_rise_s), .fall_o(href_fall_s)
    );
    cam_edge_sync u_sync_vsync (
        .clk(clk), .rst_n(rst_n), .d_i(cmos_vsync_i),
        .level_o(vsync_level_unused_s), .rise_o(vsync_rise_s), .fall_o(vsync_fall_s)
    );

    logic [7:0]        db_s1_q;
    logic [ST_W-1:0]   state_q, state_d;
    logic [X_W-1:0]    x_q, x_d, wx0_q, wx0_d, wx1_q, wx1_d;
    logic [Y_W-1:0]    y_q, y_d, wy0_q, wy0_d, wy1_q, wy1_d;
    logic [1:0]        decim_q, decim_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [PW-1:0]     pix_q, pix_d, out_data_q, out_data_d;
    logic              sof_pend_q, sof_pend_d;
    logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic              frame_done_q, frame_done_d, busy_q, busy_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              drop_s, keep_s, byte_stb_s;
    logic [X_W-1:0]    xmask_s, dx_s, last_col_s;
    logic [Y_W-1:0]    ymask_s, dy_s;

    // href high in both stages equals level high without a rise this cycle.
    assign byte_stb_s = pclk_rise_s & href_level_s & ~href_rise_s;

    assign xmask_s    = ~(X_ONES << decim_q);
    assign ymask_s    = ~(Y_ONES << decim_q);
    assign dx_s       = x_q - wx0_q;
    assign dy_s       = y_q - wy0_q;
    assign last_col_s = wx0_q + ((wx1_q - wx0_q) & ~xmask_s);
    assign keep_s     = (x_q >= wx0_q) && (x_q <= wx1_q) &&
                        (y_q >= wy0_q) && (y_q <= wy1_q) &&
                        ((dx_s & xmask_s) == {X_W{1'b0}}) &&
                        ((dy_s & ymask_s) == {Y_W{1'b0}});

    // Frame/line sequencing, pixel assembly and the keep decision.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bidx_d       = bidx_q;
        pix_d        = pix_q;
        sof_pend_d   = sof_pend_q;
        wx0_d        = wx0_q;
        wx1_d        = wx1_q;
        wy0_d        = wy0_q;
        wy1_d        = wy1_q;
        decim_d      = decim_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_eol_d    = 1'b0;
        out_data_d   = out_data_q;
        drop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WAIT_SOF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SOF: begin
                if (vsync_fall_s) begin
                    state_d    = ST_LINE;
                    wx0_d      = win_x0_i;
                    wx1_d      = win_x1_i;
                    wy0_d      = win_y0_i;
                    wy1_d      = win_y1_i;
                    decim_d    = decim_i;
                    x_d        = {X_W{1'b0}};
                    y_d        = {Y_W{1'b0}};
                    bidx_d     = {BIDX_W{1'b0}};
                    sof_pend_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_LINE: begin
                if (vsync_rise_s) begin
                    state_d      = enable_i ? ST_WAIT_SOF : ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FC_W'(1);
                end else if (href_fall_s) begin
                    x_d    = {X_W{1'b0}};
                    bidx_d = {BIDX_W{1'b0}};
                    y_d    = (y_q == Y_ONES) ? y_q : y_q + Y_W'(1);
                end else if (byte_stb_s) begin
                    pix_d = (pix_q << 4'd8) | PW'(db_s1_q);
                    if (bidx_q == BIDX_LAST) begin
                        bidx_d = {BIDX_W{1'b0}};
                        x_d    = (x_q == X_ONES) ? x_q : x_q + X_W'(1);
                        if (keep_s && out_full_i) begin
                            drop_s = 1'b1;
                        end else if (keep_s) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pix_d;
                            out_sof_d   = sof_pend_q;
                            out_eol_d   = (x_q == last_col_s);
                            sof_pend_d  = 1'b0;
                        end else begin
                            drop_s = 1'b0;
                        end
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end else begin
                    state_d = ST_LINE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sticky overflow and drop counter; a drop in the clear cycle survives.
    always_comb begin
        if (drop_s) begin
            overflow_d = 1'b1;
            drop_cnt_d = clr_status_i ? DROP_W'(1) : sat_inc_drop(drop_cnt_q);
        end else if (clr_status_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = {DROP_W{1'b0}};
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_s1_q      <= 8'd0;
            state_q      <= ST_IDLE;
            x_q          <= {X_W{1'b0}};
            y_q          <= {Y_W{1'b0}};
            bidx_q       <= {BIDX_W{1'b0}};
            pix_q        <= {PW{1'b0}};
            sof_pend_q   <= 1'b0;
            wx0_q        <= {X_W{1'b0}};
            wx1_q        <= {X_W{1'b0}};
            wy0_q        <= {Y_W{1'b0}};
            wy1_q        <= {Y_W{1'b0}};
            decim_q      <= 2'd0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_data_q   <= {PW{1'b0}};
            frame_done_q <= 1'b0;
            frame_cnt_q  <= {FC_W{1'b0}};
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= {DROP_W{1'b0}};
        end else begin
            db_s1_q      <= cmos_db_i;
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bidx_q       <= bidx_d;
            pix_q        <= pix_d;
            sof_pend_q   <= sof_pend_d;
            wx0_q        <= wx0_d;
            wx1_q        <= wx1_d;
            wy0_q        <= wy0_d;
            wy1_q        <= wy1_d;
            decim_q      <= decim_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_sof_o    = out_sof_q;
    assign out_eol_o    = out_eol_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture: drives sensor frames, predicts the
// kept pixel stream from the window rules and checks every output strobe.
module tb_cam_pixel_capture;

    localparam int BPP = 2;

    logic        clk = 1'b0;
    logic        rst_n, enable, clr_status, pclk, href, vsync, out_full;
    logic [7:0]  db;
    logic [10:0] win_x0, win_x1;
    logic [9:0]  win_y0, win_y1;
    logic [1:0]  decim;
    logic        out_valid, out_sof, out_eol, busy, frame_done, overflow;
    logic [15:0] out_data, frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    cam_pixel_capture #(.BPP(BPP)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .clr_status_i(clr_status),
        .cmos_pclk_i(pclk), .cmos_href_i(href), .cmos_vsync_i(vsync), .cmos_db_i(db),
        .win_x0_i(win_x0), .win_x1_i(win_x1), .win_y0_i(win_y0), .win_y1_i(win_y1),
        .decim_i(decim), .out_full_i(out_full),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_sof_o(out_sof),
        .out_eol_o(out_eol), .busy_o(busy), .frame_done_o(frame_done),
        .frame_cnt_o(frame_cnt), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } px_t;

    px_t         exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          fw, m_x0, m_x1, m_y0, m_y1, m_dec, last_col, ord, full_lo, full_hi;
    bit          model_on, sof_pend;
    int          log_n = 0, fd_count = 0;
    logic [15:0] log_data[0:31];
    logic        log_sof[0:31];
    logic        log_eol[0:31];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    function automatic bit model_keep(input int x, input int y);
        int step;
        step = 1 << m_dec;
        return (x >= m_x0) && (x <= m_x1) && (y >= m_y0) && (y <= m_y1) &&
               ((x - m_x0) % step == 0) && ((y - m_y0) % step == 0);
    endfunction

    function automatic logic [7:0] byte_val(input int row, input int col, input int bi);
        return 8'((row * fw + col) * BPP + bi + 1);
    endfunction

    // Every output strobe is matched against the model's next pixel.
    always @(negedge clk) begin : cmp
        px_t e;
        if (rst_n && frame_done) fd_count++;
        if (rst_n && out_valid) begin
            if (log_n < 32) begin
                log_data[log_n] = out_data;
                log_sof[log_n]  = out_sof;
                log_eol[log_n]  = out_eol;
            end
            log_n++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_px: got data 0x%0h, required no pixel", out_data);
            end else begin
                e = exp_q.pop_front();
                check("px_data", 32'(out_data), 32'(e.data));
                check("px_sof", 32'(out_sof), 32'(e.sof));
                check("px_eol", 32'(out_eol), 32'(e.eol));
            end
        end
    end

    task automatic set_win(input int w, input int x0, input int x1, input int y0, input int y1, input int d);
        fw = w; m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1; m_dec = d;
    endtask

    task automatic pclk_byte(input logic [7:0] b);
        pclk = 1'b0; db = b; #40;
        pclk = 1'b1; #40;
    endtask

    task automatic begin_frame();
        win_x0 = 11'(m_x0); win_x1 = 11'(m_x1);
        win_y0 = 10'(m_y0); win_y1 = 10'(m_y1); decim = 2'(m_dec);
        last_col = -1;
        for (int x = m_x0; x <= m_x1; x += (1 << m_dec)) last_col = x;
        ord = 0; sof_pend = 1'b1;
        #40; vsync = 1'b0; #240;
    endtask

    task automatic end_frame();
        vsync = 1'b1; #320;
    endtask

    task automatic send_line(input int row, input int nbytes);
        int  col, bi;
        bit  kept, full;
        px_t p;
        href = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            col = k / BPP; bi = k % BPP;
            if (bi == 0) begin
                kept = (k + BPP <= nbytes) && model_keep(col, row);
                full = kept && (ord >= full_lo) && (ord <= full_hi);
                out_full = full;
                if (kept) ord++;
                if (kept && !full && model_on) begin
                    p.data = {byte_val(row, col, 0), byte_val(row, col, 1)};
                    p.sof  = sof_pend;
                    p.eol  = (col == last_col);
                    sof_pend = 1'b0;
                    exp_q.push_back(p);
                end
            end
            pclk_byte(byte_val(row, col, bi));
        end
        pclk = 1'b0; #40;
        href = 1'b0; out_full = 1'b0; #240;
    endtask

    task automatic run_frame(input int h);
        begin_frame();
        for (int r = 0; r < h; r++) send_line(r, fw * BPP);
        end_frame();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_flags"}, 32'({out_valid, out_sof, out_eol, frame_done, busy, overflow}), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr_status = 1'b0; pclk = 1'b0; href = 1'b0;
        vsync = 1'b1; db = 8'd0; out_full = 1'b0; decim = 2'd0;
        win_x0 = 11'd0; win_x1 = 11'd0; win_y0 = 10'd0; win_y1 = 10'd0;
        model_on = 1'b1; full_lo = 1; full_hi = 0;
        #20; check_reset("reset");
        #10; rst_n = 1'b1;
        #20; enable = 1'b1; #40;

        // Full 4x2 frame, every pixel kept.
        set_win(4, 0, 3, 0, 1, 0); log_n = 0; run_frame(2);
        check("t1_count", 32'(log_n), 32'd8);
        check("t1_px0", 32'(log_data[0]), 32'h0102);
        check("t1_px0_sof", 32'(log_sof[0]), 32'd1);
        check("t1_px3", 32'(log_data[3]), 32'h0708);
        check("t1_px3_eol", 32'(log_eol[3]), 32'd1);
        check("t1_px7", 32'(log_data[7]), 32'h0F10);
        check("t1_px7_eol", 32'(log_eol[7]), 32'd1);
        check("t1_fcnt", 32'(frame_cnt), 32'd1);
        check("t1_fdone", 32'(fd_count), 32'd1);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Window with decimation on an 8x3 ramp.
        set_win(8, 2, 5, 1, 1, 1); log_n = 0; run_frame(3);
        check("t2_count", 32'(log_n), 32'd2);
        check("t2_px0", 32'(log_data[0]), 32'h1516);
        check("t2_px1", 32'(log_data[1]), 32'h191A);
        check("t2_px1_eol", 32'(log_eol[1]), 32'd1);
        check("t2_fcnt", 32'(frame_cnt), 32'd2);

        // Downstream full for the first three kept pixels.
        set_win(4, 0, 3, 0, 1, 0); log_n = 0; full_lo = 0; full_hi = 2; run_frame(2);
        full_lo = 1; full_hi = 0;
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd3);
        check("t3_count", 32'(log_n), 32'd5);
        check("t3_px0", 32'(log_data[0]), 32'h0708);
        check("t3_px0_sof", 32'(log_sof[0]), 32'd1);
        clr_status = 1'b1; #10; clr_status = 1'b0; #20;
        check("t3_clr_overflow", 32'(overflow), 32'd0);
        check("t3_clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Inverted column window emits nothing but still completes the frame.
        set_win(4, 5, 2, 0, 1, 0); log_n = 0; fd_count = 0; run_frame(2);
        check("t4_count", 32'(log_n), 32'd0);
        check("t4_fdone", 32'(fd_count), 32'd1);
        check("t4_fcnt", 32'(frame_cnt), 32'd4);

        // Enable dropped mid-frame: frame still completes, then idle.
        set_win(4, 0, 3, 0, 1, 0); log_n = 0;
        begin_frame(); send_line(0, 8); enable = 1'b0; send_line(1, 8); end_frame();
        check("t5_count", 32'(log_n), 32'd8);
        check("t5_fcnt", 32'(frame_cnt), 32'd5);
        check("t5_busy", 32'(busy), 32'd0);

        // Reset pulsed inside the first pixel of a line aborts the frame.
        enable = 1'b1; #40; log_n = 0; fd_count = 0;
        begin_frame(); model_on = 1'b0;
        fork
            send_line(0, 8);
            begin
                #100; rst_n = 1'b0; #20;
                check_reset("t5_rst");
                #10; rst_n = 1'b1;
            end
        join
        send_line(1, 8); end_frame();
        check("t5_abort_count", 32'(log_n), 32'd0);
        check("t5_abort_fcnt", 32'(frame_cnt), 32'd0);
        check("t5_abort_fdone", 32'(fd_count), 32'd0);
        model_on = 1'b1; run_frame(2);
        check("t5_resume_count", 32'(log_n), 32'd8);
        check("t5_resume_fcnt", 32'(frame_cnt), 32'd1);

        // Line cut after one byte; the next line must realign.
        set_win(4, 0, 3, 0, 2, 0); log_n = 0;
        begin_frame(); send_line(0, 8); send_line(1, 1); send_line(2, 8); end_frame();
        check("t6_count", 32'(log_n), 32'd8);
        check("t6_px4", 32'(log_data[4]), 32'h1112);
        check("t6_px4_sof", 32'(log_sof[4]), 32'd0);
        check("t6_fcnt", 32'(frame_cnt), 32'd2);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 Parameter BPP, default 2: bytes per pixel (1..4); pixel width PW = 8*BPP.
REQ-002 Parameter X_W, default 11: column counter width.
REQ-003 Parameter Y_W, default 10: row counter width.
REQ-004 Parameter FC_W, default 16: frame counter width.
REQ-005 Clock and reset: clk in 1, system clock, at least 4x cmos_pclk; rst_n in 1, reset, asynchronous, active-low.
REQ-006 enable in 1: capture request, sampled only at frame boundaries.
REQ-007 clr_status in 1: one-cycle pulse that clears overflow and drop_cnt.
REQ-008 cmos_pclk, cmos_href, cmos_vsync in 1 each: camera timing, asynchronous to clk.
REQ-009 cmos_db in 8: camera data byte.
REQ-010 win_x0, win_x1 in X_W each; win_y0, win_y1 in Y_W each: inclusive crop window.
REQ-011 decim in 2: keep every 2^decim-th pixel and line inside the window.
REQ-012 out_full in 1: downstream FIFO full.
REQ-013 out_valid out 1; out_data out PW: one-cycle pixel write strobe and pixel.
REQ-014 out_sof, out_eol out 1 each: first kept pixel of frame; last kept pixel of line. Both qualified by out_valid.
REQ-015 busy out 1: high outside IDLE.
REQ-016 frame_done out 1: one-cycle pulse at frame end.
REQ-017 frame_cnt out FC_W: completed frames, wraps.
REQ-018 overflow out 1: sticky flag.
REQ-019 drop_cnt out 16: count of dropped pixels, saturating.

Function
REQ-020 cmos_pclk, cmos_href, cmos_vsync and cmos_db pass through 2 flops (s1, s2); a pclk edge is s1=1, s2=0; cmos_db is taken from stage s1 on that edge.
REQ-021 A byte is accepted on a pclk edge only while href s1 and s2 are both 1 in state LINE.
REQ-022 States:
- IDLE -> WAIT_SOF when enable=1.
- WAIT_SOF -> LINE on vsync falling (s1=0, s2=1).
- LINE -> WAIT_SOF on vsync rising when enable=1.
- LINE -> IDLE on vsync rising when enable=0.
REQ-023 On vsync falling, win_*, decim are latched; x, y, byte index and the sof-pending flag reset. Mid-frame window changes have no effect until the next frame.
REQ-024 Bytes are packed MSB-first; the byte index runs 0..BPP-1. On byte BPP-1 the pixel is complete and x increments after evaluation.
REQ-025 Keep rule: win_x0<=x<=win_x1, win_y0<=y<=win_y1, (x-win_x0) mod 2^decim = 0, and (y-win_y0) mod 2^decim = 0. If win_x0>win_x1 or win_y0>win_y1, nothing is emitted.
REQ-026 A kept pixel drives out_valid=1 for exactly one clk, the cycle after the last byte's edge.
REQ-027 out_sof is 1 on the first kept pixel after vsync falling.
REQ-028 out_eol is 1 when x equals the last kept column <= win_x1.
REQ-029 If out_full=1 in the emit cycle, the pixel is dropped: out_valid stays 0, overflow is set, drop_cnt increments (saturates at 16'hFFFF). A dropped sof pixel leaves sof pending.
REQ-030 On href falling in LINE: x=0, byte index=0, y increments. A partial pixel is discarded silently.
REQ-031 x and y saturate at all-ones; no wrap inside a frame.
REQ-032 On vsync rising in LINE: frame_done pulses 1 cycle and frame_cnt increments (wraps at 2^FC_W).
REQ-033 If clr_status and a new drop occur in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
REQ-034 A vsync rising in WAIT_SOF or IDLE does not count a frame.

Reset
REQ-035 On rst_n=0: state IDLE; all synchronizer flops 0; out_valid, out_sof, out_eol, frame_done, busy, overflow = 0; out_data, frame_cnt, drop_cnt = 0; latched window = 0.
REQ-036 Reset asserted mid-frame aborts capture immediately. After release, capture resumes only after enable=1 and a fresh vsync falling.

Structure
REQ-037 A shared package holds the state encoding, BPP range limits and DROP_W=16.
REQ-038 The sub-module is cam_edge_sync: 2-flop synchronizer plus rise/fall detect, instantiated for pclk, href and vsync.

Verification
REQ-039 Test 1: BPP=2, window 0..3 x 0..1, decim=0, 4x2 frame, bytes 0x01..0x10 -> 8 pixels 0x0102..0x0F10; out_sof on 0x0102; out_eol on pixels 4 and 8; frame_cnt=1.
REQ-040 Test 2: window x 2..5, y 1..1, decim=1, 8x3 ramp -> exactly 2 pixels, at x=2 and x=4 on row 1.
REQ-041 Test 3: out_full held 1 for 3 kept pixels -> overflow=1, drop_cnt=3, those pixels absent; clr_status then clears both to 0.
REQ-042 Test 4: win_x0=5, win_x1=2 -> no out_valid; frame_done still pulses.
REQ-043 Test 5: enable dropped mid-frame -> frame completes, frame_cnt increments, state IDLE, busy=0; rst_n pulsed mid-line -> all outputs 0, no pixels until the next vsync falling after enable.
REQ-044 Test 6: href falls after 1 byte of a BPP=2 pixel -> no emit; the next line starts at x=0 with correct byte alignment.
